// File: rtl/alu_ctrl.sv
// alu_ctrl: registered, flow-controlled front end for the 8-bit 4-function ALU.
// Commands are queued in a small FIFO and executed strictly one at a time.
// Each command drives the ALU select/operand lines for one settle cycle, then
// the result is captured into the accumulator and returned on the rsp channel.
//
// Handshake rules for both channels (cmd_* and rsp_*): a transfer happens on a
// rising edge where valid and ready are both high. Once valid is raised, the
// producer holds valid and its payload stable until that transfer edge. Ready
// may change freely and does not depend on valid.
module alu_ctrl #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic             cmd_acc,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    output logic             alu_s1,
    output logic             alu_s2,
    output logic [WIDTH-1:0] alu_p,
    output logic [WIDTH-1:0] alu_q,
    input  logic [WIDTH:0]   alu_y,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH:0]   rsp_y,
    output logic             rsp_zero,
    output logic [WIDTH-1:0] acc,
    output logic [1:0]       dbg_state
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int EW = 2 + 1 + 2 * WIDTH;
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ISSUE   = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;
    localparam logic [1:0] S_RESPOND = 2'd3;

    logic [EW-1:0]    mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [1:0]       state;

    logic             push;
    logic             pop;
    logic [EW-1:0]    head;
    logic [1:0]       head_op;
    logic             head_acc;
    logic [WIDTH-1:0] head_a;
    logic [WIDTH-1:0] head_b;

    // No bypass: a full FIFO refuses a push even if a pop happens the same edge.
    assign cmd_ready = (count != FULL_CNT);
    assign push      = cmd_valid & cmd_ready;
    // Pop only when the FSM is ready to start the next command.
    assign pop       = (count != '0) &&
                       ((state == S_IDLE) || ((state == S_RESPOND) && rsp_ready));

    assign head     = mem[rd_ptr];
    assign head_op  = head[EW-1 -: 2];
    assign head_acc = head[2*WIDTH];
    assign head_a   = head[2*WIDTH-1 -: WIDTH];
    assign head_b   = head[WIDTH-1:0];

    assign dbg_state = state;

    // Command storage: write the accepted entry at the write pointer.
    always_ff @(posedge clk) begin
        if (rstn && push) begin
            mem[wr_ptr] <= {cmd_op, cmd_acc, cmd_a, cmd_b};
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally (DEPTH is a power of two).
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Execution FSM: pop -> settle -> capture -> hold response until accepted.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= S_IDLE;
            alu_s1    <= 1'b0;
            alu_s2    <= 1'b0;
            alu_p     <= '0;
            alu_q     <= '0;
            rsp_valid <= 1'b0;
            rsp_y     <= '0;
            rsp_zero  <= 1'b0;
            acc       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        alu_s1 <= head_op[1];
                        alu_s2 <= head_op[0];
                        alu_p  <= head_acc ? acc : head_a;
                        alu_q  <= head_b;
                        state  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    // The ALU leaves y[WIDTH] undriven for logic ops, so mask it.
                    rsp_y     <= {alu_y[WIDTH] & ~alu_s1, alu_y[WIDTH-1:0]};
                    rsp_zero  <= (alu_y[WIDTH-1:0] == '0);
                    acc       <= alu_y[WIDTH-1:0];
                    rsp_valid <= 1'b1;
                    state     <= S_RESPOND;
                end
                S_RESPOND: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        if (pop) begin
                            alu_s1 <= head_op[1];
                            alu_s2 <= head_op[0];
                            alu_p  <= head_acc ? acc : head_a;
                            alu_q  <= head_b;
                            state  <= S_ISSUE;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_ctrl.sv
// Bench for alu_ctrl: directed vector table, backpressure and reset sequences,
// then randomized traffic checked against a queue-based reference model.
module tb_alu_ctrl;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic             clk;
    logic             rstn;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic             cmd_acc;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic             alu_s1;
    logic             alu_s2;
    logic [WIDTH-1:0] alu_p;
    logic [WIDTH-1:0] alu_q;
    logic [WIDTH:0]   alu_y;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH:0]   rsp_y;
    logic             rsp_zero;
    logic [WIDTH-1:0] acc;
    logic [1:0]       dbg_state;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    alu_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_acc   (cmd_acc),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .alu_s1    (alu_s1),
        .alu_s2    (alu_s2),
        .alu_p     (alu_p),
        .alu_q     (alu_q),
        .alu_y     (alu_y),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_y     (rsp_y),
        .rsp_zero  (rsp_zero),
        .acc       (acc),
        .dbg_state (dbg_state)
    );

    // ---------------- external ALU model ----------------
    // Logic ops leave y[8] undriven; alu_junk stands in for whatever floats there.
    logic alu_junk;
    always_comb begin
        case ({alu_s1, alu_s2})
            2'b00:   alu_y = {1'b0, alu_p} + {1'b0, alu_q};
            2'b01:   alu_y = {1'b0, alu_p} - {1'b0, alu_q};
            2'b10:   alu_y = {alu_junk, alu_p & alu_q};
            default: alu_y = {alu_junk, alu_p ^ alu_q};
        endcase
    end

    // ---------------- scoreboard / reference model ----------------
    logic [WIDTH:0]   exp_q[$];
    logic [WIDTH-1:0] model_acc;
    int               n_cmp;
    int               n_fail;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [WIDTH:0] ref_result(input logic [1:0] op,
                                                  input logic [WIDTH-1:0] p,
                                                  input logic [WIDTH-1:0] b);
        int pi;
        int bi;
        int r;
        pi = int'(p);
        bi = int'(b);
        case (op)
            2'd0:    r = pi + bi;
            2'd1:    r = pi - bi;
            2'd2:    r = pi & bi;
            default: r = pi ^ bi;
        endcase
        return r[WIDTH:0];
    endfunction

    // Record an accepted command; returns the operand A the ALU should see.
    task automatic model_push(input logic [1:0] op, input logic accf,
                              input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                              output logic [WIDTH-1:0] p);
        logic [WIDTH:0] y;
        p = accf ? model_acc : a;
        y = ref_result(op, p, b);
        exp_q.push_back(y);
        model_acc = y[WIDTH-1:0];
    endtask

    // Response monitor: sampled 1 time unit after the falling edge.
    logic           prev_hold;
    logic [WIDTH:0] prev_y;
    initial prev_hold = 1'b0;
    always begin
        logic [WIDTH:0] e;
        @(negedge clk);
        #1;
        if (prev_hold) begin
            check("hold_valid", 32'(rsp_valid), 32'd1);
            check("hold_y", 32'(rsp_y), 32'(prev_y));
        end
        prev_hold = rstn && rsp_valid && !rsp_ready;
        prev_y    = rsp_y;
        if (rstn && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL rsp_unexpected: got 0x%0h, expected no response", rsp_y);
            end else begin
                e = exp_q.pop_front();
                check("rsp_y", 32'(rsp_y), 32'(e));
                check("rsp_zero", 32'(rsp_zero), 32'(e[WIDTH-1:0] == '0));
            end
        end
    end

    // ---------------- driver tasks ----------------
    typedef struct {
        logic [1:0]       op;
        logic             accf;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH:0]   y;
        logic             z;
        logic [WIDTH-1:0] acc;
    } vec_t;

    vec_t vecs[10];

    // Offer one command and wait (bounded) until it is accepted on the next edge.
    task automatic push_one(input logic [1:0] op, input logic accf,
                            input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            output logic [WIDTH-1:0] p, output bit ok);
        int guard;
        @(negedge clk);
        cmd_op    = op;
        cmd_acc   = accf;
        cmd_a     = a;
        cmd_b     = b;
        cmd_valid = 1'b1;
        guard     = 0;
        while (!cmd_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        ok = cmd_ready;
        p  = '0;
        if (ok) begin
            model_push(op, accf, a, b, p);
        end else begin
            check("push_timeout", 32'(cmd_ready), 32'd1);
            cmd_valid = 1'b0;
        end
    endtask

    // Single command from idle with rsp_ready high: check latency and result.
    task automatic run_vec(input vec_t v, input string tag);
        logic [WIDTH-1:0] p;
        bit               ok;
        int               lat;
        rsp_ready = 1'b1;
        push_one(v.op, v.accf, v.a, v.b, p, ok);
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'd3);
        check({tag, "_y"}, 32'(rsp_y), 32'(v.y));
        check({tag, "_zero"}, 32'(rsp_zero), 32'(v.z));
        check({tag, "_acc"}, 32'(acc), 32'(v.acc));
        check({tag, "_sel"}, 32'({alu_s1, alu_s2}), 32'(v.op));
        check({tag, "_p"}, 32'(alu_p), 32'(p));
        check({tag, "_q"}, 32'(alu_q), 32'(v.b));
    endtask

    task automatic drain(input string tag);
        int guard;
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        guard = 0;
        while ((exp_q.size() != 0 || rsp_valid) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_rsp_y"}, 32'(rsp_y), 32'd0);
        check({tag, "_rsp_zero"}, 32'(rsp_zero), 32'd0);
        check({tag, "_acc"}, 32'(acc), 32'd0);
        check({tag, "_alu_sel"}, 32'({alu_s1, alu_s2}), 32'd0);
        check({tag, "_alu_p"}, 32'(alu_p), 32'd0);
        check({tag, "_alu_q"}, 32'(alu_q), 32'd0);
    endtask

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [WIDTH-1:0] p;
        bit               ok;
        vec_t             bp[6];
        vec_t             v;
        int               n_acc;
        int               idx;
        int               cyc;
        bit               took;

        n_cmp     = 0;
        n_fail    = 0;
        model_acc = '0;
        alu_junk  = 1'b1;
        rstn      = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_acc   = 1'b0;
        cmd_a     = '0;
        cmd_b     = '0;
        rsp_ready = 1'b1;

        //            op     accf  a      b      y        z     acc
        vecs[0] = '{2'd0, 1'b0, 8'hE3, 8'h82, 9'h165, 1'b0, 8'h65};
        vecs[1] = '{2'd0, 1'b0, 8'h01, 8'hFF, 9'h100, 1'b1, 8'h00};
        vecs[2] = '{2'd1, 1'b0, 8'h02, 8'h03, 9'h1FF, 1'b0, 8'hFF};
        vecs[3] = '{2'd2, 1'b0, 8'h62, 8'h0F, 9'h002, 1'b0, 8'h02};
        vecs[4] = '{2'd0, 1'b0, 8'hFF, 8'h01, 9'h100, 1'b1, 8'h00};
        vecs[5] = '{2'd3, 1'b0, 8'h71, 8'h2A, 9'h05B, 1'b0, 8'h5B};
        vecs[6] = '{2'd0, 1'b0, 8'h10, 8'h05, 9'h015, 1'b0, 8'h15};
        vecs[7] = '{2'd1, 1'b1, 8'hAA, 8'h15, 9'h000, 1'b1, 8'h00};
        vecs[8] = '{2'd0, 1'b1, 8'h33, 8'h80, 9'h080, 1'b0, 8'h80};
        vecs[9] = '{2'd3, 1'b1, 8'h0C, 8'hFF, 9'h07F, 1'b0, 8'h7F};

        // Power-on reset
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        rstn = 1'b1;
        @(negedge clk);

        // Directed vector table
        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end
        drain("table");

        // Backpressure: 6 back-to-back offers with rsp_ready low
        for (int k = 0; k < 6; k++) begin
            bp[k].op   = 2'($urandom_range(0, 3));
            bp[k].accf = ($urandom_range(0, 3) == 0);
            bp[k].a    = 8'($urandom_range(0, 255));
            bp[k].b    = 8'($urandom_range(0, 255));
        end
        rsp_ready = 1'b0;
        n_acc = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (n_acc < 6) begin
                cmd_op    = bp[n_acc].op;
                cmd_acc   = bp[n_acc].accf;
                cmd_a     = bp[n_acc].a;
                cmd_b     = bp[n_acc].b;
                cmd_valid = 1'b1;
            end else begin
                cmd_valid = 1'b0;
            end
            if (cmd_valid && cmd_ready) begin
                model_push(bp[n_acc].op, bp[n_acc].accf, bp[n_acc].a, bp[n_acc].b, p);
                n_acc++;
            end
        end
        check("bp_accepted", 32'(n_acc), 32'd5);
        check("bp_ready_low", 32'(cmd_ready), 32'd0);
        check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_ready_after_hs", 32'(cmd_ready), 32'd1);
        if (cmd_valid && cmd_ready && n_acc == 5) begin
            model_push(bp[5].op, bp[5].accf, bp[5].a, bp[5].b, p);
            n_acc++;
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        check("bp_sixth_taken", 32'(n_acc), 32'd6);
        drain("bp");

        // Reset during CAPTURE with 3 commands still queued
        rsp_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            push_one(2'd0, 1'b0, 8'(k + 1), 8'h11, p, ok);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        cyc = 0;
        while (!rsp_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("rst_full_before", 32'(cmd_ready), 32'd0);
        rsp_ready = 1'b1;           // first response accepted at next edge
        @(negedge clk);             // now in ISSUE, 3 queued
        rsp_ready = 1'b0;
        @(negedge clk);             // now in CAPTURE, 3 queued
        rstn = 1'b0;
        exp_q.delete();
        model_acc = '0;
        @(negedge clk);
        check("rst_mid_no_valid", 32'(rsp_valid), 32'd0);
        check("rst_mid_acc", 32'(acc), 32'd0);
        @(negedge clk);
        check_reset_outputs("rst_mid");
        rstn = 1'b1;
        rsp_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("rst_quiet", 32'(rsp_valid), 32'd0);
        end
        v = '{2'd0, 1'b1, 8'hAA, 8'h07, 9'h007, 1'b0, 8'h07};
        run_vec(v, "post_rst");
        drain("post_rst");

        // Randomized traffic with random backpressure and random y[8] float
        idx  = 0;
        cyc  = 0;
        took = 1'b0;
        while (idx < 150 && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            alu_junk  = 1'($urandom_range(0, 1));
            rsp_ready = ($urandom_range(0, 3) != 0);
            if (took) begin
                cmd_valid = 1'b0;
            end
            if (!cmd_valid && $urandom_range(0, 1) == 1) begin
                cmd_op    = 2'($urandom_range(0, 3));
                cmd_acc   = ($urandom_range(0, 2) == 0);
                cmd_a     = 8'($urandom_range(0, 255));
                cmd_b     = 8'($urandom_range(0, 255));
                cmd_valid = 1'b1;
            end
            took = cmd_valid && cmd_ready;
            if (took) begin
                model_push(cmd_op, cmd_acc, cmd_a, cmd_b, p);
                idx++;
            end
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        check("rand_issued", 32'(idx), 32'd150);
        drain("rand");
        check("rand_acc", 32'(acc), 32'(model_acc));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
